// File: rtl/max6675_temp_reader.sv
// MAX6675 thermocouple reader: periodic or triggered 16-bit SPI read,
// converted to saturated 8-bit degC and degF values for the display stage.
module max6675_temp_reader #(
   parameter int unsigned CLK_DIV       = 25,
   parameter int unsigned SAMPLE_PERIOD = 6250000,
   parameter int unsigned CNT_W         = 23
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       trig,
   input  logic       spi_miso,
   output logic       spi_sck,
   output logic       spi_cs_n,
   output logic [7:0] temp_c,
   output logic [7:0] temp_f,
   output logic       open_tc,
   output logic       valid,
   output logic       busy
);

   localparam int unsigned DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned DIVISOR = 20;

   typedef enum logic [2:0] {
      IDLE,
      CS_SETUP,
      SHIFT,
      CS_HOLD,
      CONVERT,
      UPDATE
   } state_t;

   state_t           state, state_d;
   logic [CNT_W-1:0] period_cnt, period_cnt_d;
   logic [DIV_W-1:0] div_cnt, div_cnt_d;
   logic [4:0]       half_cnt, half_cnt_d;
   logic [4:0]       conv_cnt, conv_cnt_d;
   logic [15:0]      shift_reg, shift_reg_d;
   logic [15:0]      dvd, dvd_d;
   logic [4:0]       rem, rem_d;
   logic             sck_d, cs_n_d, open_tc_d, valid_d, busy_d;
   logic [7:0]       temp_c_d, temp_f_d;

   // Conversion datapath derived from the captured frame and divider state
   logic [11:0] raw;
   logic [15:0] raw_x9;
   logic [9:0]  c_full;
   logic [15:0] f_full;
   logic [7:0]  c_sat, f_sat;
   logic [5:0]  trial;
   logic        div_last;
   logic        unused_bits;

   assign raw         = shift_reg[14:3];
   assign raw_x9      = {1'b0, raw, 3'b000} + {4'b0000, raw};
   assign c_full      = raw[11:2];
   assign f_full      = dvd + 16'd32;
   assign c_sat       = (c_full > 10'd255) ? 8'd255 : c_full[7:0];
   assign f_sat       = (f_full > 16'd255) ? 8'd255 : f_full[7:0];
   assign trial       = {rem, dvd[15]};
   assign div_last    = (div_cnt == DIV_W'(CLK_DIV - 1));
   assign unused_bits = ^{shift_reg[15], shift_reg[1:0]};

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         period_cnt <= '0;
         div_cnt    <= '0;
         half_cnt   <= '0;
         conv_cnt   <= '0;
         shift_reg  <= '0;
         dvd        <= '0;
         rem        <= '0;
         spi_sck    <= 1'b0;
         spi_cs_n   <= 1'b1;
         temp_c     <= 8'd0;
         temp_f     <= 8'd32;
         open_tc    <= 1'b0;
         valid      <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state      <= state_d;
         period_cnt <= period_cnt_d;
         div_cnt    <= div_cnt_d;
         half_cnt   <= half_cnt_d;
         conv_cnt   <= conv_cnt_d;
         shift_reg  <= shift_reg_d;
         dvd        <= dvd_d;
         rem        <= rem_d;
         spi_sck    <= sck_d;
         spi_cs_n   <= cs_n_d;
         temp_c     <= temp_c_d;
         temp_f     <= temp_f_d;
         open_tc    <= open_tc_d;
         valid      <= valid_d;
         busy       <= busy_d;
      end
   end

   // Next-state, sequencing and next-output logic
   always_comb begin
      state_d      = state;
      period_cnt_d = '0;
      div_cnt_d    = div_cnt;
      half_cnt_d   = half_cnt;
      conv_cnt_d   = conv_cnt;
      shift_reg_d  = shift_reg;
      dvd_d        = dvd;
      rem_d        = rem;
      sck_d        = 1'b0;
      temp_c_d     = temp_c;
      temp_f_d     = temp_f;
      open_tc_d    = open_tc;

      case (state)
         IDLE: begin
            period_cnt_d = period_cnt + CNT_W'(1);
            if (trig || (period_cnt == CNT_W'(SAMPLE_PERIOD - 1))) begin
               state_d      = CS_SETUP;
               period_cnt_d = '0;
               div_cnt_d    = '0;
            end
         end
         CS_SETUP: begin
            if (div_last) begin
               div_cnt_d  = '0;
               half_cnt_d = '0;
               state_d    = SHIFT;
            end else begin
               div_cnt_d = div_cnt + DIV_W'(1);
            end
         end
         SHIFT: begin
            sck_d = spi_sck;
            if (div_last) begin
               div_cnt_d  = '0;
               half_cnt_d = half_cnt + 5'd1;
               if (!half_cnt[0]) begin
                  // low phase ends: raise SCK and capture SO on this edge
                  sck_d       = 1'b1;
                  shift_reg_d = {shift_reg[14:0], spi_miso};
               end else begin
                  sck_d = 1'b0;
                  if (half_cnt == 5'd31) begin
                     state_d = CS_HOLD;
                  end
               end
            end else begin
               div_cnt_d = div_cnt + DIV_W'(1);
            end
         end
         CS_HOLD: begin
            if (div_last) begin
               div_cnt_d  = '0;
               conv_cnt_d = '0;
               state_d    = CONVERT;
            end else begin
               div_cnt_d = div_cnt + DIV_W'(1);
            end
         end
         CONVERT: begin
            conv_cnt_d = conv_cnt + 5'd1;
            if (conv_cnt == 5'd0) begin
               dvd_d = raw_x9;
               rem_d = '0;
            end else if (conv_cnt <= 5'd16) begin
               // one restoring-division step by 20; quotient shifts into dvd
               if (trial >= 6'(DIVISOR)) begin
                  rem_d = 5'(trial - 6'(DIVISOR));
                  dvd_d = {dvd[14:0], 1'b1};
               end else begin
                  rem_d = trial[4:0];
                  dvd_d = {dvd[14:0], 1'b0};
               end
            end else begin
               state_d    = UPDATE;
               conv_cnt_d = '0;
               if (!shift_reg[2]) begin
                  temp_c_d  = c_sat;
                  temp_f_d  = f_sat;
                  open_tc_d = 1'b0;
               end else begin
                  open_tc_d = 1'b1;
               end
            end
         end
         UPDATE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      cs_n_d  = !((state_d == CS_SETUP) || (state_d == SHIFT) || (state_d == CS_HOLD));
      valid_d = (state_d == UPDATE);
      busy_d  = (state_d != IDLE);
   end

endmodule

// File: tb/tb_max6675_temp_reader.sv
// Directed bench for max6675_temp_reader with a behavioural MAX6675 model.
module tb_max6675_temp_reader;

   localparam int unsigned CLK_DIV       = 25;
   localparam int unsigned SAMPLE_PERIOD = 1000;
   localparam int          READ_LAT      = 869;

   logic       clk = 1'b0;
   logic       rst;
   logic       trig;
   logic       spi_miso = 1'b0;
   logic       spi_sck;
   logic       spi_cs_n;
   logic [7:0] temp_c;
   logic [7:0] temp_f;
   logic       open_tc;
   logic       valid;
   logic       busy;

   int n_checks = 0;
   int n_fail   = 0;
   int rise_cnt = 0;
   int valid_cnt = 0;

   logic [15:0] frame_q = 16'h0000;
   logic [15:0] sh      = 16'h0000;
   logic        cs_prev = 1'b1;
   logic        sck_prev = 1'b0;

   max6675_temp_reader #(
      .CLK_DIV       (CLK_DIV),
      .SAMPLE_PERIOD (SAMPLE_PERIOD),
      .CNT_W         (23)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .trig     (trig),
      .spi_miso (spi_miso),
      .spi_sck  (spi_sck),
      .spi_cs_n (spi_cs_n),
      .temp_c   (temp_c),
      .temp_f   (temp_f),
      .open_tc  (open_tc),
      .valid    (valid),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   // MAX6675 model: load frame on CS fall, next bit after each SCK fall
   always @(negedge clk) begin
      if (cs_prev && !spi_cs_n) begin
         sh = frame_q;
      end else if (sck_prev && !spi_sck && !spi_cs_n) begin
         sh = {sh[14:0], 1'b0};
      end
      spi_miso = sh[15];
      cs_prev  = spi_cs_n;
      sck_prev = spi_sck;
   end

   // SCK rising-edge counter
   always @(posedge spi_sck) rise_cnt = rise_cnt + 1;

   // valid-cycle counter
   always @(posedge clk) if (valid) valid_cnt = valid_cnt + 1;

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // wait for valid, returning edges elapsed; timeout counts as a failure
   task automatic wait_valid(output int n);
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
         if (n == 1) trig = 1'b0;
      end while (!valid && n < 3000);
      if (!valid) check_eq("valid_timeout", 0, 1);
   endtask

   // triggered read of one frame; lat = edges from trig sample to valid
   task automatic do_read(input logic [15:0] frame, output int lat, output int rises);
      int r0;
      frame_q = frame;
      @(posedge clk); #1;
      r0   = rise_cnt;
      trig = 1'b1;
      wait_valid(lat);
      rises = rise_cnt - r0;
   endtask

   task automatic wait_rises(input int base, input int target);
      int n = 0;
      while ((rise_cnt - base) < target && n < 3000) begin
         @(posedge clk); #1;
         n++;
      end
      if ((rise_cnt - base) < target) check_eq("rise_timeout", rise_cnt - base, target);
   endtask

   task automatic count_to_cs_fall(output int n);
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (spi_cs_n && n < 3000);
   endtask

   initial begin
      int lat, rises, n, r0, v0;
      rst  = 1'b1;
      trig = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_cs_n", int'(spi_cs_n), 1);
      check_eq("rst_sck", int'(spi_sck), 0);
      check_eq("rst_temp_c", int'(temp_c), 0);
      check_eq("rst_temp_f", int'(temp_f), 32);
      check_eq("rst_open_tc", int'(open_tc), 0);
      check_eq("rst_valid", int'(valid), 0);
      check_eq("rst_busy", int'(busy), 0);

      // first automatic read after reset
      frame_q = 16'h0320;
      rst = 1'b0;
      count_to_cs_fall(n);
      check_eq("first_auto_start", n, SAMPLE_PERIOD);
      check_eq("no_sck_before_read", rise_cnt, 0);
      check_eq("auto_busy", int'(busy), 1);
      wait_valid(n);
      check_eq("auto_rises", rise_cnt, 16);
      check_eq("auto_temp_c", int'(temp_c), 25);
      check_eq("auto_temp_f", int'(temp_f), 77);

      // period restarts from return to IDLE; trig mid-SHIFT is ignored
      frame_q = 16'h1900;
      @(posedge clk); #1;
      check_eq("valid_one_cycle", int'(valid), 0);
      count_to_cs_fall(n);
      check_eq("auto_period", n, SAMPLE_PERIOD);
      r0 = rise_cnt;
      v0 = valid_cnt;
      wait_rises(r0, 4);
      trig = 1'b1;
      wait_valid(n);
      check_eq("sat_800_temp_c", int'(temp_c), 200);
      check_eq("sat_800_temp_f", int'(temp_f), 255);
      repeat (50) @(posedge clk);
      #1;
      check_eq("trig_busy_valids", valid_cnt - v0, 1);
      check_eq("trig_busy_not_queued", int'(busy), 0);

      // normal triggered read with latency
      do_read(16'h0190, lat, rises);
      check_eq("normal_latency", lat, READ_LAT);
      check_eq("normal_rises", rises, 16);
      check_eq("normal_temp_c", int'(temp_c), 12);
      check_eq("normal_temp_f", int'(temp_f), 54);
      check_eq("normal_open_tc", int'(open_tc), 0);
      @(posedge clk); #1;
      check_eq("normal_valid_drop", int'(valid), 0);
      check_eq("normal_busy_drop", int'(busy), 0);

      // full-scale saturation
      do_read(16'h7FF8, lat, rises);
      check_eq("sat_max_temp_c", int'(temp_c), 255);
      check_eq("sat_max_temp_f", int'(temp_f), 255);

      // open thermocouple holds temperatures
      do_read(16'h0190, lat, rises);
      check_eq("pre_open_temp_c", int'(temp_c), 12);
      do_read(16'h0194, lat, rises);
      check_eq("open_valid", int'(valid), 1);
      check_eq("open_open_tc", int'(open_tc), 1);
      check_eq("open_temp_c", int'(temp_c), 12);
      check_eq("open_temp_f", int'(temp_f), 54);
      do_read(16'h0320, lat, rises);
      check_eq("recover_open_tc", int'(open_tc), 0);
      check_eq("recover_temp_c", int'(temp_c), 25);
      check_eq("recover_temp_f", int'(temp_f), 77);

      // reset during 8th SCK period
      frame_q = 16'h1900;
      @(posedge clk); #1;
      r0   = rise_cnt;
      trig = 1'b1;
      @(posedge clk); #1;
      trig = 1'b0;
      wait_rises(r0, 8);
      v0  = valid_cnt;
      rst = 1'b1;
      @(posedge clk); #1;
      check_eq("midrst_cs_n", int'(spi_cs_n), 1);
      check_eq("midrst_sck", int'(spi_sck), 0);
      check_eq("midrst_temp_c", int'(temp_c), 0);
      check_eq("midrst_temp_f", int'(temp_f), 32);
      check_eq("midrst_busy", int'(busy), 0);
      rst = 1'b0;
      repeat (30) @(posedge clk);
      #1;
      check_eq("midrst_no_valid", valid_cnt - v0, 0);
      do_read(16'h0320, lat, rises);
      check_eq("post_rst_latency", lat, READ_LAT);
      check_eq("post_rst_rises", rises, 16);
      check_eq("post_rst_temp_c", int'(temp_c), 25);
      check_eq("post_rst_temp_f", int'(temp_f), 77);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
